// File: rtl/nios_sd_loader_pio_read_arbiter.sv
// Two-requester read arbiter in front of a one-cycle-latency PIO slave.
// Define PIO_ARB_ROUND_ROBIN_EN for round-robin contention; otherwise requester 0 has fixed priority.
module nios_sd_loader_pio_read_arbiter #(
  parameter int unsigned ADDR_W = 2,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req_valid,
  input  logic [ADDR_W-1:0] req_address0,
  input  logic [ADDR_W-1:0] req_address1,
  output logic [1:0]        req_ack,
  output logic [1:0]        rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0] s_address,
  input  logic [DATA_W-1:0] s_readdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t state;
  logic   owner;
  logic   win_c;

`ifdef PIO_ARB_ROUND_ROBIN_EN
  // Requester favoured on the next contended grant.
  logic rr_ptr;

  always_comb begin
    win_c = 1'b0;
    if (req_valid == 2'b11) win_c = rr_ptr;
    else                    win_c = req_valid[1];
  end
`else
  always_comb begin
    win_c = 1'b0;
    win_c = ~req_valid[0];
  end
`endif

  // Grant in IDLE, wait out the slave latency in ISSUE, capture data in RESP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      owner     <= 1'b0;
      req_ack   <= 2'b00;
      rsp_valid <= 2'b00;
      rsp_data  <= '0;
      s_address <= '0;
`ifdef PIO_ARB_ROUND_ROBIN_EN
      rr_ptr    <= 1'b0;
`endif
    end else begin
      req_ack   <= 2'b00;
      rsp_valid <= 2'b00;
      case (state)
        IDLE: begin
          if (|req_valid) begin
            owner     <= win_c;
            s_address <= win_c ? req_address1 : req_address0;
            req_ack   <= win_c ? 2'b10 : 2'b01;
`ifdef PIO_ARB_ROUND_ROBIN_EN
            rr_ptr    <= ~win_c;
`endif
            state     <= ISSUE;
          end
        end
        ISSUE: state <= RESP;
        RESP: begin
          rsp_data  <= s_readdata;
          rsp_valid <= owner ? 2'b10 : 2'b01;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
